// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path constants and the per-edge operation decode used by the
// PC register and the IF/ID register.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    OP_RUN      = 2'd0,
    OP_STALL    = 2'd1,
    OP_REDIRECT = 2'd2
  } fetch_op_e;

  // A redirect outranks a stall so a wrong-path fetch can never be held.
  function automatic fetch_op_e decode_op(input logic branch_taken, input logic stall);
    fetch_op_e op;
    if (branch_taken) begin
      op = OP_REDIRECT;
    end else if (stall) begin
      op = OP_STALL;
    end else begin
      op = OP_RUN;
    end
    return op;
  endfunction

endpackage

// File: rtl/fetch_stage_checker.sv
// Runtime invariants of the IF/ID register: a bubble carries NOP at address 0,
// and the fetch counter never moves backwards outside reset.
module fetch_stage_checker #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  input logic [DATA_W-1:0] inst_id,
  input logic [ADDR_W-1:0] pc_id,
  input logic              valid_id,
  input logic [CNT_W-1:0]  fetch_count
);

  bubble_is_nop: assert property (@(posedge clk) disable iff (reset)
    !valid_id |-> (inst_id == '0 && pc_id == '0));

  count_monotonic: assert property (@(posedge clk) disable iff (reset)
    fetch_count >= $past(fetch_count));

endmodule

// File: rtl/pc_reg.sv
// Program counter: async reset, redirect/stall/increment selection and
// modulo-2^ADDR_W wrap on sequential fetch.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  fetch_op_e         op,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_next;

  // Next-PC select; the increment drops its carry so the last word wraps to 0.
  always_comb begin
    pc_next = pc;
    case (op)
      OP_REDIRECT: pc_next = branch_target;
      OP_STALL:    pc_next = pc;
      OP_RUN:      pc_next = pc + ONE;
      default:     pc_next = pc;
    endcase
  end

  // PC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_ADDR;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC (via pc_reg), drives the IM address and
// holds the IF/ID register plus a saturating count of valid fetches.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] addressIM,
  input  logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_id,
  output logic [ADDR_W-1:0] pc_id,
  output logic              valid_id,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [DATA_W-1:0] NOP_W    = DATA_W'(NOP);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_PC  = ADDR_W'(0);

  fetch_op_e         op;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count_inc;

  assign op        = decode_op(branch_taken, stall);
  assign addressIM = pc;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .branch_target (branch_target),
    .pc            (pc)
  );

  // Saturating increment: an all-ones counter stays put.
  always_comb begin
    if (&fetch_count) begin
      count_inc = fetch_count;
    end else begin
      count_inc = fetch_count + CNT_ONE;
    end
  end

  // IF/ID register; a redirect loads a bubble to squash the wrong-path word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_id  <= NOP_W;
      pc_id    <= ZERO_PC;
      valid_id <= 1'b0;
    end else begin
      case (op)
        OP_REDIRECT: begin
          inst_id  <= NOP_W;
          pc_id    <= ZERO_PC;
          valid_id <= 1'b0;
        end
        OP_STALL: begin
          inst_id  <= inst_id;
          pc_id    <= pc_id;
          valid_id <= valid_id;
        end
        OP_RUN: begin
          inst_id  <= inst;
          pc_id    <= pc;
          valid_id <= 1'b1;
        end
        default: begin
          inst_id  <= NOP_W;
          pc_id    <= ZERO_PC;
          valid_id <= 1'b0;
        end
      endcase
    end
  end

  // Fetch counter advances only when a real instruction is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (op == OP_RUN) begin
      fetch_count <= count_inc;
    end else begin
      fetch_count <= fetch_count;
    end
  end

  fetch_stage_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .inst_id     (inst_id),
    .pc_id       (pc_id),
    .valid_id    (valid_id),
    .fetch_count (fetch_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues the expected IF/ID state
// for each edge, a monitor pops and compares shortly after every rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [4:0]  branch_target;
  logic [4:0]  addressIM;
  logic [31:0] inst, inst_id;
  logic [4:0]  pc_id;
  logic        valid_id;
  logic [15:0] fetch_count;

  logic        reset2;
  logic [4:0]  addr2, pc_id2;
  logic [31:0] inst2, inst_id2;
  logic        valid2;
  logic [3:0]  cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          sat;
    logic        valid;
    logic [4:0]  pcid;
    int          cnt;
    int          addr;
    string       name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] im(input logic [4:0] a);
    return 32'hA500_0000 | {27'd0, a};
  endfunction

  assign inst  = im(addressIM);
  assign inst2 = im(addr2);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .addressIM     (addressIM),
    .inst          (inst),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .valid_id      (valid_id),
    .fetch_count   (fetch_count)
  );

  fetch_stage #(.CNT_W(4)) dut_sat (
    .clk           (clk),
    .reset         (reset2),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (5'd0),
    .addressIM     (addr2),
    .inst          (inst2),
    .inst_id       (inst_id2),
    .pc_id         (pc_id2),
    .valid_id      (valid2),
    .fetch_count   (cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic st, input logic br, input logic [4:0] tgt,
                      input logic ev, input int epc, input int ecnt, input int eaddr,
                      input string nm);
    exp_t e;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    e.sat   = 1'b0;
    e.valid = ev;
    e.pcid  = 5'(epc);
    e.cnt   = ecnt;
    e.addr  = eaddr;
    e.name  = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare queued expectations against the DUT just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sat) begin
          chk({e.name, "_cnt"}, {60'd0, cnt2}, 64'(e.cnt));
        end else begin
          chk({e.name, "_valid"}, {63'd0, valid_id}, {63'd0, e.valid});
          chk({e.name, "_inst"},  {32'd0, inst_id}, {32'd0, (e.valid ? im(e.pcid) : 32'h0)});
          chk({e.name, "_pc_id"}, {59'd0, pc_id}, {59'd0, e.pcid});
          chk({e.name, "_count"}, {48'd0, fetch_count}, 64'(e.cnt));
          chk({e.name, "_addr"},  {59'd0, addressIM}, 64'(e.addr));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
    @(negedge clk);
    chk("rst_addr",  {59'd0, addressIM}, 64'd0);
    chk("rst_valid", {63'd0, valid_id}, 64'd0);
    chk("rst_count", {48'd0, fetch_count}, 64'd0);
    chk("rst_inst",  {32'd0, inst_id}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // sequential fetch from RESET_PC
    step(1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 1, "seq0");
    step(1'b0, 1'b0, 5'd0, 1'b1, 1, 2, 2, "seq1");
    step(1'b0, 1'b0, 5'd0, 1'b1, 2, 3, 3, "seq2");
    step(1'b0, 1'b0, 5'd0, 1'b1, 3, 4, 4, "seq3");
    step(1'b0, 1'b0, 5'd0, 1'b1, 4, 5, 5, "seq4");

    // redirect at pc=5 to 20: one bubble, count unchanged
    step(1'b0, 1'b1, 5'd20, 1'b0, 0, 5, 20, "branch");

    // fetch 20..31 then wrap through 0..6
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b1, (20 + i) % 32, 6 + i, (21 + i) % 32, "wrap");
    end

    // stall three cycles at pc=7
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b1, 6, 24, 7, "stall");
    end
    step(1'b0, 1'b0, 5'd0, 1'b1, 7, 25, 8, "unstall7");
    step(1'b0, 1'b0, 5'd0, 1'b1, 8, 26, 9, "unstall8");

    // branch wins over a simultaneous stall
    step(1'b1, 1'b1, 5'd3, 1'b0, 0, 26, 3, "stall_branch");
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 5'd0, 1'b1, 3 + i, 27 + i, 4 + i, "after_redirect");
    end

    // async reset between edges at pc=12
    chk("pre_reset_addr", {59'd0, addressIM}, 64'd12);
    #1 reset = 1'b1;
    #1;
    chk("async_addr",  {59'd0, addressIM}, 64'd0);
    chk("async_valid", {63'd0, valid_id}, 64'd0);
    chk("async_count", {48'd0, fetch_count}, 64'd0);
    chk("async_inst",  {32'd0, inst_id}, 64'd0);
    chk("async_pc_id", {59'd0, pc_id}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 1'b0, 5'd0, 1'b1, 0, 1, 1, "post_reset0");
    step(1'b0, 1'b0, 5'd0, 1'b1, 1, 2, 2, "post_reset1");

    // 4-bit counter saturates at 15
    reset2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      e.sat   = 1'b1;
      e.valid = 1'b1;
      e.pcid  = 5'd0;
      e.cnt   = (i + 1 > 15) ? 15 : i + 1;
      e.addr  = 0;
      e.name  = "saturate";
      q.push_back(e);
      @(negedge clk);
    end

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
